// File: rtl/reg_dump_streamer.sv
// Snapshots a register file on a trigger rising edge and streams it out one
// register per valid/ready beat, then pulses dump_done and counts the dump.
module reg_dump_streamer #(
  parameter  int NREGS = 32,
  parameter  int WIDTH = 64,
  localparam int IDX_W = (NREGS > 1) ? $clog2(NREGS) : 1
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         trigger,
  input  logic [NREGS-1:0][WIDTH-1:0]  debug_reg_out,
  input  logic                         dump_ready,
  output logic                         dump_valid,
  output logic [IDX_W-1:0]             dump_index,
  output logic [WIDTH-1:0]             dump_data,
  output logic                         busy,
  output logic                         dump_done,
  output logic [7:0]                   dump_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NREGS - 1);

  state_t                       state;
  state_t                       next_state;
  logic [IDX_W-1:0]             index;
  logic                         trigger_prev;
  logic                         trigger_rise;
  logic [NREGS-1:0][WIDTH-1:0]  snapshot;

  assign trigger_rise = trigger && !trigger_prev;

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Edges arriving outside IDLE are simply dropped; nothing is queued.
  always_comb begin
    next_state = state;
    dump_valid = 1'b0;
    busy       = 1'b0;
    dump_done  = 1'b0;
    case (state)
      IDLE: begin
        if (trigger_rise) begin
          next_state = SEND;
        end
      end
      SEND: begin
        dump_valid = 1'b1;
        busy       = 1'b1;
        if (dump_ready && (index == LAST_IDX)) begin
          next_state = DONE;
        end
      end
      DONE: begin
        dump_done  = 1'b1;
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      index        <= '0;
      trigger_prev <= 1'b0;
      dump_count   <= 8'd0;
    end else begin
      trigger_prev <= trigger;
      if ((state == IDLE) && trigger_rise) begin
        index <= '0;
      end
      if ((state == SEND) && dump_ready && (index != LAST_IDX)) begin
        index <= index + IDX_W'(1);
      end
      if ((state == DONE) && (dump_count != 8'hFF)) begin
        dump_count <= dump_count + 8'd1;
      end
    end
  end

  // Snapshot is only loaded on an accepted trigger, so it is frozen for the
  // whole dump; its contents are never looked at outside SEND, hence no reset.
  always_ff @(posedge clock) begin
    if ((state == IDLE) && trigger_rise && !reset) begin
      snapshot <= debug_reg_out;
    end
  end

  assign dump_index = index;
  assign dump_data  = snapshot[index];

endmodule

// File: doc/reg_dump_streamer.md
REG_DUMP_STREAMER -- requirements
Module: reg_dump_streamer

Interface
REQ-001 SHALL have parameter NREGS, default 32: number of architectural registers snapshotted and streamed.
REQ-002 SHALL have parameter WIDTH, default 64: bit width of each register.
REQ-003 SHALL have port clock, input, 1: sole clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port trigger, input, 1: dump request, driven from full_machine except or an end-of-run flag; level signal.
REQ-006 SHALL have port debug_reg_out, input, [NREGS-1:0][WIDTH-1:0]: live register-file contents from full_machine.
REQ-007 SHALL have port dump_ready, input, 1: consumer accepts the current beat.
REQ-008 SHALL have port dump_valid, output, 1: beat on dump_index/dump_data is valid.
REQ-009 SHALL have port dump_index, output, $clog2(NREGS): register number of the current beat.
REQ-010 SHALL have port dump_data, output, WIDTH: snapshotted value of register dump_index.
REQ-011 SHALL have port busy, output, 1: high while a dump is in progress (SEND state).
REQ-012 SHALL have port dump_done, output, 1: one-cycle pulse when the final beat is accepted.
REQ-013 SHALL have port dump_count, output, 8: number of completed dumps, saturating at 255.

Function
REQ-014 SHALL implement states IDLE, SEND, DONE.
REQ-015 SHALL detect a trigger rising edge as trigger==1 while the registered previous trigger==0.
REQ-016 SHALL, in IDLE on a rising edge, copy all NREGS entries of debug_reg_out into an internal snapshot array in that cycle, set index to 0, and enter SEND next cycle.
REQ-017 SHALL ignore rising edges and level trigger while in SEND or DONE; no second dump queued.
REQ-018 SHALL, in SEND, drive dump_valid=1, dump_index=index, dump_data=snapshot[index].
REQ-019 SHALL hold dump_index and dump_data stable while dump_valid=1 and dump_ready=0.
REQ-020 SHALL treat a beat as transferred only in a cycle where dump_valid=1 and dump_ready=1.
REQ-021 SHALL increment index by 1 on each transfer when index < NREGS-1.
REQ-022 SHALL, on the transfer with index == NREGS-1, enter DONE; the index SHALL NOT wrap to 0 in SEND.
REQ-023 SHALL in DONE drive dump_valid=0, dump_done=1 for exactly one cycle, increment dump_count unless 255, then return to IDLE.
REQ-024 SHALL drive dump_valid=0 and dump_done=0 in IDLE; busy=1 only in SEND.
REQ-025 SHALL never alter the snapshot during SEND even if debug_reg_out changes.
REQ-026 SHALL accept dump_ready asserted without dump_valid with no effect.
REQ-027 SHALL sustain one beat per cycle when dump_ready is held high: NREGS beats in NREGS consecutive cycles, dump_done the cycle after the last beat.
REQ-028 SHALL treat a trigger held high across DONE->IDLE as no new edge; a new dump requires trigger to drop then rise.

Reset
REQ-029 SHALL on reset=1 at a clock edge set state IDLE, index 0, previous-trigger 0, dump_count 0; dump_valid, busy, dump_done 0 from the following cycle.
REQ-030 SHALL, on reset mid-SEND, abandon the dump without dump_done and without incrementing dump_count.
REQ-031 SHALL treat a trigger already high when reset deasserts as a rising edge (previous-trigger resets to 0).
REQ-032 SHALL NOT require snapshot contents to be reset; dump_data is don't-care while dump_valid=0.

Verification
REQ-033 SHALL pass: debug_reg_out[i]=i*0x1111, trigger 0->1, dump_ready=1 -> 32 beats indices 0..31, data i*0x1111, dump_done one cycle after beat 31, dump_count=1.
REQ-034 SHALL pass: dump_ready toggled 1,0,0,1,... with debug_reg_out changed to all-ones after trigger -> beats keep snapshot values, index/data stable during stalls, no beat lost or repeated.
REQ-035 SHALL pass: trigger pulsed again at beat 10 and held high through DONE -> single dump only; dump_count=1 until trigger drops and rises again.
REQ-036 SHALL pass: reset asserted at beat 20 -> next cycle dump_valid=0, busy=0, no dump_done, dump_count=0; fresh trigger restarts at index 0.
REQ-037 SHALL pass: 256 back-to-back complete dumps -> dump_count saturates at 255.
